i2c_regmem_read_prefetch: RTL and testbench

- Read-side sequencer between the I2C slave byte engine and the 4Kx8 read port of the register mirror memory.
- Holds a 12-bit byte pointer that the I2C master loads. It auto-increments and pre-fetches bytes into a small FIFO, so a byte is always ready the moment the slave engine shifts out the next one.
- It absorbs the memory's fixed read latency and discards stale returns when the pointer is reloaded.

---
 rtl/i2c_regmem_read_prefetch.sv | 166 ++++++++++++++++
 tb/tb_i2c_regmem_read_prefetch.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regmem_read_prefetch.sv
// ---------------------------------------------------------------------------
// i2c_regmem_read_prefetch
//
// Read-side sequencer between the I2C slave byte engine and the read port of
// the register mirror memory. A byte pointer loaded by the I2C master is
// auto-incremented, and bytes are pre-fetched into a small FIFO so that the
// next byte is ready before the slave engine asks for it. The memory has a
// fixed read latency with no handshake. A valid-bit shift register tracks
// outstanding reads, so returns issued before a pointer reload can be dropped.
//
// Ports
//   iClk        system clock, rising edge
//   iRst_n      asynchronous active-low reset
//   iPtrLoad    strobe: load ivPtr as the new read pointer (flushes FIFO)
//   ivPtr       new pointer value, sampled with iPtrLoad
//   iRdReq      strobe: consume the head byte
//   ovRdData    head byte, valid while oRdRdy=1 (0 otherwise)
//   oRdRdy      FIFO not empty
//   ovHeadAddr  byte address of ovRdData
//   oUnderflow  one-cycle pulse after an iRdReq that found the FIFO empty
//   ovMemAddr   registered read address to the memory
//   ivMemData   memory read data, RD_LAT clocks after ovMemAddr
// ---------------------------------------------------------------------------
module i2c_regmem_read_prefetch #(
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 2,
   parameter int DEPTH  = 2
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iPtrLoad,
   input  logic [ADDR_W-1:0] ivPtr,
   input  logic              iRdReq,
   output logic [7:0]        ovRdData,
   output logic              oRdRdy,
   output logic [ADDR_W-1:0] ovHeadAddr,
   output logic              oUnderflow,
   output logic [ADDR_W-1:0] ovMemAddr,
   input  logic [7:0]        ivMemData
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CR_W  = $clog2(DEPTH + RD_LAT + 3);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_fetch_ptr;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] r_head_addr;
   // Bit 0 is set on the edge a fetch is issued (address visible that
   // cycle); bit RD_LAT is set while the matching ivMemData is valid.
   logic [RD_LAT:0]   r_vld;
   logic [7:0]        r_fifo [DEPTH];
   logic [IDX_W-1:0]  r_wr_idx;
   logic [IDX_W-1:0]  r_rd_idx;
   logic [CNT_W-1:0]  r_count;
   logic              r_underflow;

   logic              w_rdy;
   logic              w_consume;
   logic              w_return;
   logic              w_issue;
   logic [CR_W-1:0]   w_inflight;
   logic [CR_W-1:0]   w_credit;
   logic [CR_W-1:0]   w_credit_after_pop;
   logic [CR_W-1:0]   w_next_credit;

   function automatic logic [IDX_W-1:0] f_idx_inc(input logic [IDX_W-1:0] v);
      return (v == IDX_W'(DEPTH - 1)) ? '0 : v + IDX_W'(1);
   endfunction

   // Credit accounting: FIFO entries plus outstanding reads never exceed
   // DEPTH, so a returning byte always finds a free slot. A read consumed
   // this cycle frees its slot immediately, letting a fetch issue on the
   // same edge and keeping back-to-back reads gap-free once DEPTH covers
   // the round trip.
   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so no path through the block leaves a value held (which
   // would infer a latch).
   always_comb begin
      w_rdy      = (r_count != '0);
      w_consume  = iRdReq & w_rdy & ~iPtrLoad;
      w_return   = r_vld[RD_LAT];
      w_inflight = '0;
      for (int i = 0; i <= RD_LAT; i++) begin
         w_inflight = w_inflight + CR_W'(r_vld[i]);
      end
      w_credit           = CR_W'(r_count) + w_inflight;
      w_credit_after_pop = w_credit - CR_W'(w_consume);
      w_issue            = (r_state != S_IDLE) && !iPtrLoad &&
                           (w_credit_after_pop < CR_W'(DEPTH));
      w_next_credit      = w_credit_after_pop + CR_W'(w_issue);
   end

   always_comb begin
      w_next_state = r_state;
      if (iPtrLoad) begin
         w_next_state = S_FILL;
      end else if (r_state != S_IDLE) begin
         w_next_state = (w_next_credit == CR_W'(DEPTH)) ? S_READY : S_FILL;
      end
   end

   // NOTE: clocked state uses non-blocking '<=' so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state     <= S_IDLE;
         r_fetch_ptr <= '0;
         r_mem_addr  <= '0;
         r_head_addr <= '0;
         r_vld       <= '0;
         r_wr_idx    <= '0;
         r_rd_idx    <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (iPtrLoad) begin
            // The load edge itself issues the fetch of ivPtr and wipes all
            // older in-flight reads, so stale returns never reach the FIFO.
            r_mem_addr  <= ivPtr;
            r_fetch_ptr <= ivPtr + ADDR_W'(1);
            r_head_addr <= ivPtr;
            r_vld       <= {{RD_LAT{1'b0}}, 1'b1};
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
         end else begin
            r_vld <= {r_vld[RD_LAT-1:0], w_issue};
            if (w_issue) begin
               r_mem_addr  <= r_fetch_ptr;
               r_fetch_ptr <= r_fetch_ptr + ADDR_W'(1);
            end
            if (w_return) begin
               r_wr_idx <= f_idx_inc(r_wr_idx);
            end
            if (w_consume) begin
               r_rd_idx    <= f_idx_inc(r_rd_idx);
               r_head_addr <= r_head_addr + ADDR_W'(1);
            end
            r_count     <= r_count + CNT_W'(w_return) - CNT_W'(w_consume);
            r_underflow <= iRdReq & ~w_rdy;
         end
      end
   end

   // NOTE: the FIFO storage has no reset; occupancy is governed by r_count
   // and the read port is gated while empty, so stale contents never leak.
   always_ff @(posedge iClk) begin
      if (!iPtrLoad && w_return) begin
         r_fifo[r_wr_idx] <= ivMemData;
      end
   end

   assign ovRdData   = w_rdy ? r_fifo[r_rd_idx] : 8'h00;
   assign oRdRdy     = w_rdy;
   assign ovHeadAddr = r_head_addr;
   assign oUnderflow = r_underflow;
   assign ovMemAddr  = r_mem_addr;

endmodule

// File: tb/tb_i2c_regmem_read_prefetch.sv
// ---------------------------------------------------------------------------
// Testbench for i2c_regmem_read_prefetch. Two instances (DEPTH=2 and DEPTH=4)
// share one stimulus stream; each has its own memory model returning
// addr[7:0]^0xA5 RD_LAT clocks after the address. Directed scenarios are
// followed by randomized traffic checked against a transaction-level model
// (byte count, queue of pending return times, expected head pointer).
// ---------------------------------------------------------------------------
module tb_i2c_regmem_read_prefetch;

   localparam int ADDR_W = 12;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ptr_load = 1'b0;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] ptr = '0;

   logic [7:0]        rd_data2, rd_data4, mem_data2, mem_data4;
   logic              rdy2, rdy4, uf2, uf4;
   logic [ADDR_W-1:0] head2, head4, mem_addr2, mem_addr4;
   logic [ADDR_W-1:0] pipe2 [RD_LAT];
   logic [ADDR_W-1:0] pipe4 [RD_LAT];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   i2c_regmem_read_prefetch #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .DEPTH(2)) u_dut2 (
      .iClk(clk), .iRst_n(rst_n), .iPtrLoad(ptr_load), .ivPtr(ptr), .iRdReq(rd_req),
      .ovRdData(rd_data2), .oRdRdy(rdy2), .ovHeadAddr(head2), .oUnderflow(uf2),
      .ovMemAddr(mem_addr2), .ivMemData(mem_data2));

   i2c_regmem_read_prefetch #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .DEPTH(4)) u_dut4 (
      .iClk(clk), .iRst_n(rst_n), .iPtrLoad(ptr_load), .ivPtr(ptr), .iRdReq(rd_req),
      .ovRdData(rd_data4), .oRdRdy(rdy4), .ovHeadAddr(head4), .oUnderflow(uf4),
      .ovMemAddr(mem_addr4), .ivMemData(mem_data4));

   function automatic logic [7:0] f_byte(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   // Memory models: the address seen during cycle k is answered during k+RD_LAT.
   always @(posedge clk) begin
      pipe2[0] <= mem_addr2;
      pipe4[0] <= mem_addr4;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe2[i] <= pipe2[i-1];
         pipe4[i] <= pipe4[i-1];
      end
   end
   assign mem_data2 = f_byte(pipe2[RD_LAT-1]);
   assign mem_data4 = f_byte(pipe4[RD_LAT-1]);

   // Advance to the next cycle (1 ns after the edge) and drop the strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      ptr_load = 1'b0;
      rd_req   = 1'b0;
   endtask

   task automatic test_reset();
      int busy;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (mem_addr2 !== 12'h000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr2); end
      checks++; if (rd_data2 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data2); end
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", rdy2); end
      checks++; if (head2 !== 12'h000) begin errors++; $display("FAIL reset_head got=%h exp=000", head2); end
      checks++; if (uf2 !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", uf2); end
      checks++; if ({mem_addr4, rd_data4, rdy4, head4, uf4} !== '0) begin
         errors++; $display("FAIL reset_dut4_outputs got=%h exp=0", {mem_addr4, rd_data4, rdy4, head4, uf4});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      busy = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (mem_addr2 !== 12'h000 || rdy2 !== 1'b0) busy++;
         tick();
      end
      checks++; if (busy != 0) begin errors++; $display("FAIL idle_no_fetch got=%0d active cycles exp=0", busy); end
   endtask

   // Load 0x010: address next cycle, data ready 4 clocks after the strobe,
   // then the DEPTH=2 FIFO holds 0x010/0x011 and the fetch pointer rests at 0x012.
   task automatic test_load_latency();
      ptr = 12'h010; ptr_load = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (mem_addr2 !== 12'h010) begin errors++; $display("FAIL load_mem_addr got=%h exp=010", mem_addr2); end
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin tick(); @(negedge clk); end
         checks++;
         if (rdy2 !== (k == 4)) begin errors++; $display("FAIL load_rdy_clk%0d got=%b exp=%b", k, rdy2, (k == 4)); end
      end
      checks++; if (rd_data2 !== 8'hB5) begin errors++; $display("FAIL load_first_data got=%h exp=B5", rd_data2); end
      checks++; if (head2 !== 12'h010) begin errors++; $display("FAIL load_first_head got=%h exp=010", head2); end
      repeat (4) tick();
      @(negedge clk);
      checks++; if (mem_addr2 !== 12'h011) begin errors++; $display("FAIL fill_last_mem_addr got=%h exp=011", mem_addr2); end
      checks++; if (u_dut2.r_fetch_ptr !== 12'h012) begin errors++; $display("FAIL fill_fetch_ptr got=%h exp=012", u_dut2.r_fetch_ptr); end
      checks++; if (int'(u_dut2.r_count) != 2) begin errors++; $display("FAIL fill_count got=%0d exp=2", u_dut2.r_count); end
      tick();
   endtask

   task automatic test_spaced_reads();
      logic [7:0] exp_seq [8] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6, 8'hB1, 8'hB0, 8'hB3, 8'hB2};
      int uf_seen;
      for (int i = 0; i < 8; i++) begin
         rd_req = 1'b1;
         @(negedge clk);
         checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL spaced_rdy[%0d] got=%b exp=1", i, rdy2); end
         checks++; if (rd_data2 !== exp_seq[i]) begin errors++; $display("FAIL spaced_data[%0d] got=%h exp=%h", i, rd_data2, exp_seq[i]); end
         checks++; if (head2 !== 12'(12'h010 + i)) begin errors++; $display("FAIL spaced_head[%0d] got=%h exp=%h", i, head2, 12'(12'h010 + i)); end
         tick();
         uf_seen = 0;
         for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (uf2 !== 1'b0) uf_seen++;
            tick();
         end
         checks++; if (uf_seen != 0) begin errors++; $display("FAIL spaced_underflow[%0d] got=%0d pulses exp=0", i, uf_seen); end
      end
      @(negedge clk);
      checks++; if (head2 !== 12'h018) begin errors++; $display("FAIL spaced_final_head got=%h exp=018", head2); end
      tick();
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] exp_addr, prev_ma;
      int reads;
      bit saw_wrap;
      reads = 0; saw_wrap = 1'b0; prev_ma = mem_addr2;
      ptr = 12'hFFE; ptr_load = 1'b1;
      tick();
      for (int k = 0; k < 40 && reads < 4; k++) begin
         @(negedge clk);
         if (prev_ma == 12'hFFF && mem_addr2 == 12'h000) saw_wrap = 1'b1;
         prev_ma = mem_addr2;
         if (rdy2) begin
            exp_addr = 12'(12'hFFE + reads);
            checks++; if (head2 !== exp_addr) begin errors++; $display("FAIL wrap_head[%0d] got=%h exp=%h", reads, head2, exp_addr); end
            checks++; if (rd_data2 !== f_byte(exp_addr)) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", reads, rd_data2, f_byte(exp_addr)); end
            rd_req = 1'b1;
            reads++;
         end
         tick();
      end
      checks++; if (reads != 4) begin errors++; $display("FAIL wrap_reads_timeout got=%0d exp=4", reads); end
      checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_mem_addr got=no FFF->000 step exp=step seen"); end
   endtask

   // Load 0x100 then 0x200 two clocks later: nothing from 0x100/0x101 may
   // surface and the first byte appears 4 clocks after the second load.
   task automatic test_reload();
      int first_k, bad;
      bit seen;
      first_k = -1; bad = 0; seen = 1'b0;
      ptr = 12'h100; ptr_load = 1'b1;
      tick();
      tick();
      ptr = 12'h200; ptr_load = 1'b1;
      tick();
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rdy2) begin
            if (!seen) begin
               seen = 1'b1; first_k = k;
               checks++; if (head2 !== 12'h200) begin errors++; $display("FAIL reload_first_head got=%h exp=200", head2); end
               checks++; if (rd_data2 !== 8'hA5) begin errors++; $display("FAIL reload_first_data got=%h exp=A5", rd_data2); end
            end
            if (head2 == 12'h100 || head2 == 12'h101 || rd_data2 !== f_byte(head2)) bad++;
            rd_req = (k % 2 == 0);
         end
         tick();
      end
      checks++; if (first_k != 3) begin errors++; $display("FAIL reload_latency got=%0d exp=3", first_k); end
      checks++; if (bad != 0) begin errors++; $display("FAIL reload_stale got=%0d bad bytes exp=0", bad); end
   endtask

   task automatic test_underflow();
      ptr = 12'h300; ptr_load = 1'b1;
      tick();
      rd_req = 1'b1;
      @(negedge clk);
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL uf_pre_rdy got=%b exp=0", rdy2); end
      tick();
      @(negedge clk);
      checks++; if (uf2 !== 1'b1) begin errors++; $display("FAIL uf_pulse got=%b exp=1", uf2); end
      tick();
      @(negedge clk);
      checks++; if (uf2 !== 1'b0) begin errors++; $display("FAIL uf_pulse_end got=%b exp=0", uf2); end
      tick();
      @(negedge clk);
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL uf_after_rdy got=%b exp=1", rdy2); end
      checks++; if (head2 !== 12'h300) begin errors++; $display("FAIL uf_after_head got=%h exp=300", head2); end
      checks++; if (rd_data2 !== 8'hA5) begin errors++; $display("FAIL uf_after_data got=%h exp=A5", rd_data2); end
      repeat (3) tick();
      // Collision while data is ready: load wins, nothing is consumed.
      ptr = 12'h040; ptr_load = 1'b1; rd_req = 1'b1;
      @(negedge clk);
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL coll_pre_rdy got=%b exp=1", rdy2); end
      tick();
      // Collision while empty: load wins, no underflow pulse.
      ptr = 12'h050; ptr_load = 1'b1; rd_req = 1'b1;
      @(negedge clk);
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL coll1_rdy got=%b exp=0", rdy2); end
      checks++; if (head2 !== 12'h040) begin errors++; $display("FAIL coll1_head got=%h exp=040", head2); end
      checks++; if (uf2 !== 1'b0) begin errors++; $display("FAIL coll1_underflow got=%b exp=0", uf2); end
      tick();
      @(negedge clk);
      checks++; if (uf2 !== 1'b0) begin errors++; $display("FAIL coll2_underflow got=%b exp=0", uf2); end
      checks++; if (head2 !== 12'h050) begin errors++; $display("FAIL coll2_head got=%h exp=050", head2); end
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL coll2_rdy got=%b exp=0", rdy2); end
      repeat (3) tick();
      @(negedge clk);
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL coll_ready got=%b exp=1", rdy2); end
      checks++; if (head2 !== 12'h050) begin errors++; $display("FAIL coll_ready_head got=%h exp=050", head2); end
      checks++; if (rd_data2 !== 8'hF5) begin errors++; $display("FAIL coll_ready_data got=%h exp=F5", rd_data2); end
      tick();
   endtask

   // Async reset mid-fill, then DEPTH=4 sustains one read per clock.
   task automatic test_reset_back_to_back();
      logic [ADDR_W-1:0] exp_addr;
      int busy;
      ptr = 12'h500; ptr_load = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({mem_addr4, rd_data4, rdy4, head4, uf4} !== '0) begin
         errors++; $display("FAIL async_reset_dut4 got=%h exp=0", {mem_addr4, rd_data4, rdy4, head4, uf4});
      end
      checks++; if ({mem_addr2, rd_data2, rdy2, head2, uf2} !== '0) begin
         errors++; $display("FAIL async_reset_dut2 got=%h exp=0", {mem_addr2, rd_data2, rdy2, head2, uf2});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      busy = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (mem_addr4 !== 12'h000 || rdy4 !== 1'b0) busy++;
         tick();
      end
      checks++; if (busy != 0) begin errors++; $display("FAIL post_reset_idle got=%0d active cycles exp=0", busy); end
      ptr = 12'hFF8; ptr_load = 1'b1;
      tick();
      repeat (10) tick();
      for (int k = 0; k < 16; k++) begin
         exp_addr = 12'(12'hFF8 + k);
         rd_req = 1'b1;
         @(negedge clk);
         checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got=%b exp=1", k, rdy4); end
         checks++; if (head4 !== exp_addr) begin errors++; $display("FAIL b2b_head[%0d] got=%h exp=%h", k, head4, exp_addr); end
         checks++; if (rd_data4 !== f_byte(exp_addr)) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, rd_data4, f_byte(exp_addr)); end
         tick();
      end
   endtask

   // Random loads/reads against a transaction model: a byte count, a queue
   // of cycles on which outstanding reads land, and the expected head pointer.
   task automatic test_random(input int sel, input int n_cycles);
      int depth, m_count, cnt_now;
      int pend[$];
      logic [ADDR_W-1:0] m_head, p, o_head;
      logic m_uf, ld, rd, o_rdy, o_uf;
      logic [7:0] o_data;
      bit consume, ret, issue;
      depth = (sel == 0) ? 2 : 4;
      m_count = 0; m_head = '0; m_uf = 1'b0;
      for (int c = 0; c < n_cycles; c++) begin
         ld = (c == 0) || ($urandom_range(0, 19) == 0);
         p  = 12'($urandom);
         rd = ($urandom_range(0, 2) == 0);
         ptr_load = ld; ptr = p; rd_req = rd;
         @(negedge clk);
         o_rdy  = (sel == 0) ? rdy2 : rdy4;
         o_data = (sel == 0) ? rd_data2 : rd_data4;
         o_head = (sel == 0) ? head2 : head4;
         o_uf   = (sel == 0) ? uf2 : uf4;
         cnt_now = (sel == 0) ? int'(u_dut2.r_count) : int'(u_dut4.r_count);
         if (c > 0) begin
            checks++; if (o_rdy !== (m_count > 0)) begin errors++; $display("FAIL rand%0d_rdy c=%0d got=%b exp=%b", depth, c, o_rdy, (m_count > 0)); end
            checks++; if (o_uf !== m_uf) begin errors++; $display("FAIL rand%0d_underflow c=%0d got=%b exp=%b", depth, c, o_uf, m_uf); end
            checks++; if (o_head !== m_head) begin errors++; $display("FAIL rand%0d_head c=%0d got=%h exp=%h", depth, c, o_head, m_head); end
            checks++; if (cnt_now > depth) begin errors++; $display("FAIL rand%0d_overflow c=%0d got=%0d exp<=%0d", depth, c, cnt_now, depth); end
            if (m_count > 0) begin
               checks++; if (o_data !== f_byte(m_head)) begin errors++; $display("FAIL rand%0d_data c=%0d got=%h exp=%h", depth, c, o_data, f_byte(m_head)); end
            end
         end
         if (ld) begin
            m_count = 0;
            pend.delete();
            pend.push_back(c + 1 + RD_LAT);
            m_head = p;
            m_uf = 1'b0;
         end else begin
            consume = rd && (m_count > 0);
            m_uf    = rd && (m_count == 0);
            issue   = (m_count + pend.size() - int'(consume)) < depth;
            ret     = (pend.size() > 0) && (pend[0] == c);
            if (ret) begin void'(pend.pop_front()); m_count++; end
            if (consume) begin m_count--; m_head = m_head + 12'd1; end
            if (issue) pend.push_back(c + 1 + RD_LAT);
         end
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_load_latency();
      test_spaced_reads();
      test_wrap();
      test_reload();
      test_underflow();
      test_reset_back_to_back();
      test_random(0, 600);
      test_random(1, 600);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
